// File: rtl/cf_gpio_cfg_bank.sv
// cf_gpio_cfg_bank: per-channel pad configuration bank with a glitch-safe
// mode-change sequencer. A write parks the target pad in plain INPUT for
// SETTLE_CYCLES cycles, then applies the new mode.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | accepting writes (cfg_ready=1)
// ST_SAFE  | target channel forced to INPUT while the counter runs down
// ST_APPLY | target decodes the new mode; registers commit at end of cycle
module cf_gpio_cfg_bank #(
  parameter int         NUM_CH        = 4,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [2:0] RESET_MODE    = 3'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_ch,
  input  logic [2:0]            cfg_mode,
  input  logic [1:0]            cfg_analog,
  output logic                  cfg_ready,
  output logic                  cfg_err,
  input  logic [NUM_CH-1:0]     io_out,
  input  logic [NUM_CH-1:0]     io_oeb,
  output logic [NUM_CH-1:0]     io_in,
  input  logic [NUM_CH-1:0]     gpio_in,
  output logic [3*NUM_CH-1:0]   gpio_dm,
  output logic [NUM_CH-1:0]     gpio_inp_dis,
  output logic [NUM_CH-1:0]     gpio_oeb_out,
  output logic [NUM_CH-1:0]     gpio_out_val,
  output logic [NUM_CH-1:0]     gpio_analog_en,
  output logic [NUM_CH-1:0]     gpio_analog_sel,
  output logic [NUM_CH-1:0]     gpio_analog_pol,
  output logic [NUM_CH-1:0]     gpio_ib_mode_sel,
  output logic [NUM_CH-1:0]     gpio_vtrip_sel,
  output logic [NUM_CH-1:0]     gpio_slow_sel,
  output logic [NUM_CH-1:0]     gpio_holdover,
  output logic [3*NUM_CH-1:0]   mode_o
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  localparam logic [2:0] M_ANALOG   = 3'd0;
  localparam logic [2:0] M_INPUT    = 3'd1;
  localparam logic [2:0] M_INPUT_PD = 3'd2;
  localparam logic [2:0] M_INPUT_PU = 3'd3;
  localparam logic [2:0] M_OUTPUT   = 3'd4;
  localparam logic [2:0] M_BIDIR    = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_SAFE, ST_APPLY} state_t;

  state_t                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [4:0]                  tgt_ch_q, tgt_ch_d;
  logic [2:0]                  tgt_mode_q, tgt_mode_d;
  logic [1:0]                  tgt_ana_q, tgt_ana_d;
  logic [NUM_CH-1:0][2:0]      mode_q, mode_d;
  logic [NUM_CH-1:0][1:0]      ana_q, ana_d;
  logic                        cfg_err_q, cfg_err_d;
  logic [NUM_CH-1:0]           sync1_q, sync1_d;
  logic [NUM_CH-1:0]           sync2_q, sync2_d;

  logic [2:0]                  cur_mode;
  logic [1:0]                  cur_ana;
  logic                        ch_ok, mode_ok, wr_try, wr_valid, wr_bad, wr_same;

  logic [NUM_CH-1:0][2:0]      dm_c;

  // Qualify the incoming write against the addressed channel's stored setting.
  always_comb begin
    cur_mode = '0;
    cur_ana  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (5'(i) == cfg_ch) begin
        cur_mode = mode_q[i];
        cur_ana  = ana_q[i];
      end
    end
    ch_ok    = (32'(cfg_ch) < NUM_CH);
    mode_ok  = (cfg_mode <= M_BIDIR);
    wr_try   = cfg_we && (state_q == ST_IDLE);
    wr_valid = wr_try && ch_ok && mode_ok;
    wr_bad   = wr_try && !(ch_ok && mode_ok);
    wr_same  = (cur_mode == cfg_mode) && (cur_ana == cfg_analog);
  end

  // Bank sequencer next-state, settle counter and register commit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_ch_d   = tgt_ch_q;
    tgt_mode_d = tgt_mode_q;
    tgt_ana_d  = tgt_ana_q;
    mode_d     = mode_q;
    ana_d      = ana_q;
    cfg_err_d  = wr_bad;
    case (state_q)
      ST_IDLE: begin
        if (wr_valid && !wr_same) begin
          state_d    = ST_SAFE;
          cnt_d      = CNT_W'(SETTLE_CYCLES);
          tgt_ch_d   = cfg_ch;
          tgt_mode_d = cfg_mode;
          tgt_ana_d  = cfg_analog;
        end
      end
      ST_SAFE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_APPLY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_APPLY: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (5'(i) == tgt_ch_q) begin
            mode_d[i] = tgt_mode_q;
            ana_d[i]  = tgt_ana_q;
          end
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    sync1_d = gpio_in;
    sync2_d = sync1_q;
  end

  // State and configuration registers; reset drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      tgt_ch_q   <= '0;
      tgt_mode_q <= '0;
      tgt_ana_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i] <= RESET_MODE;
        ana_q[i]  <= 2'b00;
      end
      cfg_err_q  <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_ch_q   <= tgt_ch_d;
      tgt_mode_q <= tgt_mode_d;
      tgt_ana_q  <= tgt_ana_d;
      mode_q     <= mode_d;
      ana_q      <= ana_d;
      cfg_err_q  <= cfg_err_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  // Pad decode; the target channel shows INPUT while settling and the new
  // mode during APPLY so the pad never falls back to the old mode.
  always_comb begin
    dm_c            = '0;
    gpio_inp_dis    = '0;
    gpio_oeb_out    = '0;
    gpio_out_val    = '0;
    gpio_analog_en  = '0;
    gpio_analog_sel = '0;
    gpio_analog_pol = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      logic [2:0] eff_mode;
      logic [1:0] eff_ana;
      eff_mode = mode_q[i];
      eff_ana  = ana_q[i];
      if (5'(i) == tgt_ch_q) begin
        if (state_q == ST_SAFE) begin
          eff_mode = M_INPUT;
          eff_ana  = 2'b00;
        end else if (state_q == ST_APPLY) begin
          eff_mode = tgt_mode_q;
          eff_ana  = tgt_ana_q;
        end
      end
      dm_c[i]         = 3'b001;
      gpio_oeb_out[i] = 1'b1;
      case (eff_mode)
        M_ANALOG: begin
          dm_c[i]            = 3'b000;
          gpio_inp_dis[i]    = 1'b1;
          gpio_analog_en[i]  = 1'b1;
          gpio_analog_sel[i] = eff_ana[1];
          gpio_analog_pol[i] = eff_ana[0];
        end
        M_INPUT_PD: begin
          dm_c[i]         = 3'b011;
          gpio_oeb_out[i] = 1'b0;
        end
        M_INPUT_PU: begin
          dm_c[i]         = 3'b010;
          gpio_oeb_out[i] = 1'b0;
          gpio_out_val[i] = 1'b1;
        end
        M_OUTPUT: begin
          dm_c[i]         = 3'b110;
          gpio_inp_dis[i] = 1'b1;
          gpio_oeb_out[i] = 1'b0;
          gpio_out_val[i] = io_out[i];
        end
        M_BIDIR: begin
          dm_c[i]         = 3'b110;
          gpio_oeb_out[i] = io_oeb[i];
          gpio_out_val[i] = io_out[i];
        end
        default: ;
      endcase
    end
  end

  assign gpio_dm          = dm_c;
  assign mode_o           = mode_q;
  assign cfg_ready        = (state_q == ST_IDLE);
  assign cfg_err          = cfg_err_q;
  assign io_in            = sync2_q;
  assign gpio_ib_mode_sel = '0;
  assign gpio_vtrip_sel   = '0;
  assign gpio_slow_sel    = '0;
  assign gpio_holdover    = '0;

endmodule
